// File: rtl/bus_initiator_if.sv
// ---------------------------------------------------------------------------
// bus_initiator_if
//   Groups the host request/response handshake and the 8088-style bus
//   control/address signals of bus_initiator. The bidirectional DATA bus is
//   kept as a plain top-level inout so the tristate stays at a module pin.
//
//   Host side : REQ_VALID, REQ_READY, REQ_WR, REQ_IO, REQ_ADDR, REQ_WDATA,
//               DONE, ERR, RDATA
//   Bus side  : ALE, IOM, RD (active low), WR (active low), READY, ADDRESS
//
//   Modports: master = the initiator itself, slave = host + responder view.
// ---------------------------------------------------------------------------
interface bus_initiator_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8
);
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WR;
  logic                  REQ_IO;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_WDATA;
  logic                  DONE;
  logic                  ERR;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  ALE;
  logic                  IOM;
  logic                  RD;
  logic                  WR;
  logic                  READY;
  logic [ADDR_WIDTH-1:0] ADDRESS;

  modport master (
    input  REQ_VALID, REQ_WR, REQ_IO, REQ_ADDR, REQ_WDATA, READY,
    output REQ_READY, DONE, ERR, RDATA, ALE, IOM, RD, WR, ADDRESS
  );

  modport slave (
    output REQ_VALID, REQ_WR, REQ_IO, REQ_ADDR, REQ_WDATA, READY,
    input  REQ_READY, DONE, ERR, RDATA, ALE, IOM, RD, WR, ADDRESS
  );
endinterface

// File: rtl/bus_initiator.sv
// ---------------------------------------------------------------------------
// bus_initiator
//   Runs one bus cycle per accepted host request: T1 (address/ALE),
//   T2 (strobe), optional TW wait states while READY is low, T3 (strobe
//   release), T4 (DONE pulse). A wait-state count reaching MAX_WAIT with
//   READY still low aborts the cycle and reports ERR with DONE.
//
//   Ports:
//     CLK    - clock, all state changes on the rising edge
//     RESET  - synchronous, active-high reset
//     DATA   - bidirectional data bus, driven only in T2/TW/T3 of a write
//     bus    - bus_initiator_if.master (host handshake + bus control)
// ---------------------------------------------------------------------------
module bus_initiator #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  CLK,
  input  logic                  RESET,
  inout  wire  [DATA_WIDTH-1:0] DATA,
  bus_initiator_if.master       bus
);

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4} state_t;

  localparam logic [7:0] MAX_WAIT_CNT = 8'(MAX_WAIT);

  state_t                state;
  state_t                state_next;
  logic                  wr_q;
  logic                  io_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [7:0]            wait_cnt;
  logic                  timeout_q;

  logic req_ready;
  logic accept;
  logic sample;
  logic wait_hit;
  logic strobe;
  logic drive_data;

  assign req_ready = (state == IDLE) || (state == T4);
  assign accept    = bus.REQ_VALID && req_ready;
  assign sample    = (state == T2) || (state == TW);
  assign wait_hit  = (wait_cnt == MAX_WAIT_CNT);
  assign strobe    = sample;

  // Next-state logic. READY is only meaningful at the end of T2/TW.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = T1;
      T1:      state_next = T2;
      T2, TW:  begin
        if (bus.READY || wait_hit) state_next = T3;
        else                       state_next = TW;
      end
      T3:      state_next = T4;
      T4:      state_next = accept ? T1 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (RESET) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      io_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      hold_q    <= '0;
      rdata_q   <= '0;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_next;

      if (accept) begin
        wr_q      <= bus.REQ_WR;
        io_q      <= bus.REQ_IO;
        addr_q    <= bus.REQ_ADDR;
        wdata_q   <= bus.REQ_WDATA;
        timeout_q <= 1'b0;
      end

      if (state == T1) wait_cnt <= '0;

      if (sample) begin
        if (bus.READY) begin
          if (!wr_q) hold_q <= DATA;
        end else if (wait_hit) begin
          timeout_q <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end

      // Publish read data on entry to T4 so it is valid alongside DONE;
      // aborted reads leave the previous value untouched.
      if ((state == T3) && !wr_q && !timeout_q) rdata_q <= hold_q;
    end
  end

  assign drive_data = wr_q && ((state == T2) || (state == TW) || (state == T3));
  assign DATA       = drive_data ? wdata_q : {DATA_WIDTH{1'bz}};

  assign bus.REQ_READY = req_ready;
  assign bus.ALE       = (state == T1);
  assign bus.IOM       = io_q;
  assign bus.ADDRESS   = addr_q;
  assign bus.RD        = !(strobe && !wr_q);
  assign bus.WR        = !(strobe && wr_q);
  assign bus.DONE      = (state == T4);
  assign bus.ERR       = (state == T4) && timeout_q;
  assign bus.RDATA     = rdata_q;

endmodule

// File: tb/tb_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_bus_initiator
//   Directed bench for bus_initiator: a table of single transactions with
//   hand-computed latency/strobe/data expectations, plus hand-written
//   back-to-back and reset-during-wait sequences. The bench plays both the
//   host and a responder that drives DATA while RD is low.
// ---------------------------------------------------------------------------
module tb_bus_initiator;
  localparam int AW = 20;
  localparam int DW = 8;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          reset;
  wire  [DW-1:0] data;
  logic [DW-1:0] resp_data;

  bus_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bus_initiator #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_WAIT  (MW)
  ) dut (
    .CLK  (clk),
    .RESET(reset),
    .DATA (data),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Responder drives the data bus only while the read strobe is active.
  assign data = (bus.RD == 1'b0) ? resp_data : {DW{1'bz}};

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          wr;
    logic          io;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] resp;
    int            waits;      // READY=0 samples before READY=1
    int            exp_lat;    // cycle index of DONE after the accept edge
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_strobe; // cycles with the active strobe low
  } vec_t;

  vec_t vecs[7];

  task automatic run_txn(input vec_t v);
    int            lat      = 0;
    int            ale_n    = 0;
    int            strobe_n = 0;
    int            nz       = 0;
    logic          err_seen = 1'b0;
    logic          released = 1'b0;
    logic [DW-1:0] rdata_seen = '0;
    logic [DW-1:0] stored     = '0;
    logic          addr_ok  = 1'b1;
    logic          iom_ok   = 1'b1;
    logic          data_ok  = 1'b1;
    logic          wrong_strobe = 1'b0;
    logic          err_leak = 1'b0;

    @(negedge clk);
    check("req_ready_before_accept", bus.REQ_READY, 1);
    bus.REQ_VALID = 1'b1;
    bus.REQ_WR    = v.wr;
    bus.REQ_IO    = v.io;
    bus.REQ_ADDR  = v.addr;
    bus.REQ_WDATA = v.wdata;
    bus.READY     = 1'b1;
    resp_data     = v.resp;

    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      // Mid-transaction request noise must not disturb the cycle.
      if (c == 1) bus.REQ_VALID = 1'b0;
      if (c == 2) begin
        bus.REQ_VALID = 1'b1;
        bus.REQ_ADDR  = ~v.addr;
        bus.REQ_WR    = ~v.wr;
        bus.REQ_IO    = ~v.io;
      end
      if (c == 3) bus.REQ_VALID = 1'b0;

      if (bus.ALE) ale_n++;
      if (bus.ADDRESS !== v.addr) addr_ok = 1'b0;
      if (bus.IOM !== v.io) iom_ok = 1'b0;
      if (v.wr ? !bus.RD : !bus.WR) wrong_strobe = 1'b1;
      if (bus.ERR && !bus.DONE) err_leak = 1'b1;

      if (!bus.RD || !bus.WR) begin
        strobe_n++;
        bus.READY = (nz >= v.waits);
        if (!bus.READY) nz++;
        if (v.wr && (data !== v.wdata)) data_ok = 1'b0;
        if (!bus.WR && bus.READY) stored = data;
      end else begin
        bus.READY = 1'b1;
      end

      if (bus.DONE) begin
        lat        = c;
        err_seen   = bus.ERR;
        rdata_seen = bus.RDATA;
        released   = bus.RD && bus.WR;
      end
    end

    check("done_latency", lat, v.exp_lat);
    check("err_with_done", err_seen, v.exp_err);
    check("rdata", rdata_seen, v.exp_rdata);
    check("ale_cycles", ale_n, 1);
    check("strobe_low_cycles", strobe_n, v.exp_strobe);
    check("address_held", addr_ok, 1);
    check("iom_held", iom_ok, 1);
    check("no_wrong_strobe", wrong_strobe, 0);
    check("strobes_released_t4", released, 1);
    check("err_only_with_done", err_leak, 0);
    if (v.wr) begin
      check("write_data_driven", data_ok, 1);
      if (!v.exp_err) check("responder_stored", stored, v.wdata);
    end

    @(negedge clk);
    check("done_one_cycle", bus.DONE, 0);
    check("err_low_after_done", bus.ERR, 0);
    check("idle_req_ready", bus.REQ_READY, 1);
    bus.READY = 1'b1;
  endtask

  initial begin
    int done_n;

    //           wr    io    addr       wdata  resp   wt  lat err   rdata  strobe
    vecs[0] = '{1'b0, 1'b0, 20'h12345, 8'h00, 8'hA5, 0,  4, 1'b0, 8'hA5, 1};
    vecs[1] = '{1'b1, 1'b1, 20'h00080, 8'h3C, 8'h00, 0,  4, 1'b0, 8'hA5, 1};
    vecs[2] = '{1'b0, 1'b0, 20'h54321, 8'h00, 8'h5A, 2,  6, 1'b0, 8'h5A, 3};
    vecs[3] = '{1'b0, 1'b1, 20'h0F0F0, 8'h00, 8'h77, 99, 7, 1'b1, 8'h5A, 4};
    vecs[4] = '{1'b1, 1'b0, 20'hFFFFF, 8'hC3, 8'h00, 1,  5, 1'b0, 8'h5A, 2};
    vecs[5] = '{1'b1, 1'b1, 20'h00001, 8'h99, 8'h00, 99, 7, 1'b1, 8'h5A, 4};
    vecs[6] = '{1'b0, 1'b0, 20'h00000, 8'h00, 8'h00, 0,  4, 1'b0, 8'h00, 1};

    reset         = 1'b1;
    bus.REQ_VALID = 1'b0;
    bus.REQ_WR    = 1'b0;
    bus.REQ_IO    = 1'b0;
    bus.REQ_ADDR  = '0;
    bus.REQ_WDATA = '0;
    bus.READY     = 1'b1;
    resp_data     = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ale", bus.ALE, 0);
    check("rst_rd", bus.RD, 1);
    check("rst_wr", bus.WR, 1);
    check("rst_iom", bus.IOM, 0);
    check("rst_address", bus.ADDRESS, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_err", bus.ERR, 0);
    check("rst_rdata", bus.RDATA, 0);
    check("rst_req_ready", bus.REQ_READY, 1);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Back-to-back reads with REQ_VALID held high across the T4 accept.
    @(negedge clk);
    bus.REQ_VALID = 1'b1;
    bus.REQ_WR    = 1'b0;
    bus.REQ_IO    = 1'b0;
    bus.REQ_ADDR  = 20'h00100;
    resp_data     = 8'h11;
    @(posedge clk);
    repeat (4) @(negedge clk);
    check("b2b_first_done", bus.DONE, 1);
    check("b2b_first_rdata", bus.RDATA, 8'h11);
    check("b2b_ready_in_t4", bus.REQ_READY, 1);
    bus.REQ_ADDR = 20'h00200;
    resp_data    = 8'h22;
    @(negedge clk);
    check("b2b_second_ale", bus.ALE, 1);
    check("b2b_second_address", bus.ADDRESS, 20'h00200);
    check("b2b_busy_in_t1", bus.REQ_READY, 0);
    bus.REQ_VALID = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_second_done", bus.DONE, 1);
    check("b2b_second_rdata", bus.RDATA, 8'h22);
    @(negedge clk);

    // Reset in the middle of a write wait state.
    bus.REQ_VALID = 1'b1;
    bus.REQ_WR    = 1'b1;
    bus.REQ_IO    = 1'b1;
    bus.REQ_ADDR  = 20'h33333;
    bus.REQ_WDATA = 8'hE7;
    bus.READY     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.REQ_VALID = 1'b0;
    repeat (2) @(negedge clk);
    check("tw_write_strobe", bus.WR, 0);
    check("tw_write_data", data, 8'hE7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.READY = 1'b1;
    check("rst_mid_wr", bus.WR, 1);
    check("rst_mid_rd", bus.RD, 1);
    check("rst_mid_ale", bus.ALE, 0);
    check("rst_mid_done", bus.DONE, 0);
    check("rst_mid_req_ready", bus.REQ_READY, 1);
    check("rst_mid_rdata", bus.RDATA, 0);
    check("rst_mid_address", bus.ADDRESS, 0);
    done_n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.DONE) done_n++;
    end
    check("rst_mid_no_done", done_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
